// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: transmitter state encoding and codeword bit positions.
// Used by the encoder and the matching decoder.
package hamming_pkg;

  localparam int unsigned CwW = 7;

  // Data bits d0..d3 and parity bits p0..p2 within the 7-bit codeword.
  localparam int unsigned DataPos0 = 2;
  localparam int unsigned DataPos1 = 4;
  localparam int unsigned DataPos2 = 5;
  localparam int unsigned DataPos3 = 6;
  localparam int unsigned ParPos0  = 0;
  localparam int unsigned ParPos1  = 1;
  localparam int unsigned ParPos2  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Syndrome value equals the 1-based position of a single flipped bit.
  function automatic logic [2:0] hamming_syndrome(logic [CwW-1:0] cw);
    return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
            cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
            cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction

endpackage

// File: rtl/hamming_encode_core.sv
// Combinational Hamming(7,4) encoder: nibble in, 7-bit codeword out.
module hamming_encode_core
  import hamming_pkg::*;
(
  input  logic [3:0]     data_i,
  output logic [CwW-1:0] code_o
);

  always_comb begin
    code_o           = '0;
    code_o[DataPos0] = data_i[0];
    code_o[DataPos1] = data_i[1];
    code_o[DataPos2] = data_i[2];
    code_o[DataPos3] = data_i[3];
    code_o[ParPos0]  = data_i[0] ^ data_i[1] ^ data_i[3];
    code_o[ParPos1]  = data_i[0] ^ data_i[2] ^ data_i[3];
    code_o[ParPos2]  = data_i[1] ^ data_i[2] ^ data_i[3];
  end

endmodule

// File: rtl/hamming_encoder_tx.sv
// Hamming(7,4) serial transmitter: start bit, 7 codeword bits LSB first, stop bit.
// Define HAMMING_ERR_INJECT_EN to add the inject_pos single-bit error injection port.
module hamming_encoder_tx
  import hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic           clk,
  input  logic           rst,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [2:0]     inject_pos,
`endif
  input  logic [3:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           tx,
  output logic           busy,
  output logic [CwW-1:0] codeword
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [CwW-1:0]  codeword_q, codeword_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ready_q;
  logic [CwW-1:0]  clean_cw;
  logic [CwW-1:0]  enc_cw;

  hamming_encode_core u_core (
    .data_i (in_data),
    .code_o (clean_cw)
  );

`ifdef HAMMING_ERR_INJECT_EN
  always_comb begin
    enc_cw = clean_cw;
    if (inject_pos != 3'd0) begin
      enc_cw = clean_cw ^ (7'b1 << (inject_pos - 3'd1));
    end
  end
`else
  assign enc_cw = clean_cw;
`endif

  // ready_q keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_q && (state_q == StIdle);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign codeword = codeword_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    codeword_d = codeword_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d    = StStart;
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          codeword_d = enc_cw;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == CntMax) begin
          state_d = StData;
          cnt_d   = '0;
          tx_d    = codeword_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd6) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = codeword_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntMax) begin
          state_d   = StIdle;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      codeword_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      codeword_q <= codeword_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Self-checking bench for hamming_encoder_tx: table of nibbles plus frame-level corner sequences.
module tb_hamming_encoder_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data0, in_data1;
  logic       in_valid0, in_valid1;
  logic       in_ready0, in_ready1;
  logic       tx0, tx1;
  logic       busy0, busy1;
  logic [6:0] codeword0, codeword1;
  logic [2:0] inj_tb = 3'd0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [6:0] sb[$];

  always #5 clk = ~clk;

  hamming_encoder_tx #(.CLKS_PER_BIT(4)) u_dut0 (
    .clk      (clk),
`ifdef HAMMING_ERR_INJECT_EN
    .inject_pos (inj_tb),
`endif
    .rst      (rst),
    .in_data  (in_data0),
    .in_valid (in_valid0),
    .in_ready (in_ready0),
    .tx       (tx0),
    .busy     (busy0),
    .codeword (codeword0)
  );

  hamming_encoder_tx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk      (clk),
`ifdef HAMMING_ERR_INJECT_EN
    .inject_pos (3'd0),
`endif
    .rst      (rst),
    .in_data  (in_data1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .tx       (tx1),
    .busy     (busy1),
    .codeword (codeword1)
  );

  function automatic logic [6:0] model_cw(logic [3:0] d, logic [2:0] pos);
    logic [6:0] c;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    if (pos != 3'd0) c[pos - 3'd1] = ~c[pos - 3'd1];
    return c;
  endfunction

  // Scoreboard push at every accept of the 4-clock DUT.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid0 && in_ready0) begin
      sb.push_back(model_cw(in_data0, inj_tb));
      acc_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready0();
    int n = 0;
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready0_timeout", 64'd0, 64'd1);
  endtask

  task automatic accept0(input logic [3:0] d);
    in_data0  = d;
    in_valid0 = 1'b1;
    wait_ready0();
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; returns at the negedge of cycle 37.
  task automatic capture_frame(output logic [6:0] rx);
    logic [35:0] wave, bsy, expw;
    logic [6:0]  exp;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
      exp = 7'h00;
    end else begin
      exp = sb.pop_front();
    end
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      wave[k] = tx0;
      bsy[k]  = busy0;
      if (k == 0) chk("codeword_out", codeword0, exp);
    end
    for (int i = 0; i < 7; i++) rx[i] = wave[4 + 4 * i + 1];
    for (int k = 0; k < 36; k++) begin
      if (k < 4) expw[k] = 1'b0;
      else if (k < 32) expw[k] = exp[(k - 4) / 4];
      else expw[k] = 1'b1;
    end
    chk("tx_wave", wave, expw);
    chk("busy_wave", bsy, {36{1'b1}});
    chk("rx_vs_sb", rx, exp);
    @(negedge clk);
    chk("idle_after_frame", {in_ready0, busy0, tx0}, 3'b101);
  endtask

  typedef struct {
    logic [3:0] d;
    logic [6:0] cw;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] rx;
    logic [8:0] w1, b1, r1;
    int         a1;

    tbl[0] = '{d: 4'hB, cw: 7'h55};
    tbl[1] = '{d: 4'h0, cw: 7'h00};
    tbl[2] = '{d: 4'hF, cw: 7'h7F};
    tbl[3] = '{d: 4'h1, cw: 7'h07};
    tbl[4] = '{d: 4'h3, cw: 7'h1E};
    tbl[5] = '{d: 4'hC, cw: 7'h61};

    rst = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_data0 = 4'h0;
    in_data1 = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_state", {tx0, busy0, in_ready0, codeword0}, {3'b100, 7'h00});
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      accept0(tbl[i].d);
      capture_frame(rx);
      chk("tbl_rx", rx, tbl[i].cw);
      chk("tbl_cw_hold", codeword0, tbl[i].cw);
    end

    // Back-to-back accepts with in_valid held; in_data changes mid-frame.
    in_data0  = 4'h3;
    in_valid0 = 1'b1;
    wait_ready0();
    @(posedge clk);
    #1;
    a1 = acc_cyc;
    in_data0 = 4'hC;
    capture_frame(rx);
    chk("b2b_first_rx", rx, 7'h1E);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    chk("accept_spacing", acc_cyc - a1, 37);
    in_data0 = 4'h5;
    capture_frame(rx);
    chk("b2b_second_rx", rx, 7'h61);

    // Reset during DATA bit 3 aborts the frame.
    accept0(4'h9);
    repeat (17) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_abort", {tx0, busy0, in_ready0, codeword0}, {3'b100, 7'h00});
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_hold", {tx0, busy0}, 2'b10);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release", {in_ready0, busy0, tx0}, 3'b101);
    accept0(4'hB);
    capture_frame(rx);
    chk("post_rst_rx", rx, 7'h55);

    // One clock per bit.
    in_data1  = 4'hB;
    in_valid1 = 1'b1;
    begin
      int n = 0;
      while (!in_ready1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("ready1_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      w1[k] = tx1;
      b1[k] = busy1;
      r1[k] = in_ready1;
    end
    chk("c1_tx_wave", w1, {1'b1, 7'h55, 1'b0});
    chk("c1_busy_wave", b1, 9'h1FF);
    chk("c1_ready_low", r1, 9'h000);
    chk("c1_codeword", codeword1, 7'h55);
    @(negedge clk);
    chk("c1_cycle10", {in_ready1, busy1, tx1}, 3'b101);

`ifdef HAMMING_ERR_INJECT_EN
    begin
      logic [2:0] syn;
      logic [6:0] fix;
      inj_tb    = 3'd3;
      in_data0  = 4'hF;
      in_valid0 = 1'b1;
      wait_ready0();
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      inj_tb    = 3'd0;
      capture_frame(rx);
      chk("inj_cw", codeword0, 7'h7B);
      syn = {rx[3] ^ rx[4] ^ rx[5] ^ rx[6], rx[1] ^ rx[2] ^ rx[5] ^ rx[6],
             rx[0] ^ rx[2] ^ rx[4] ^ rx[6]};
      chk("inj_err_flag", (syn != 3'd0), 1'b1);
      fix = rx;
      if (syn != 3'd0) fix[syn - 3'd1] = ~fix[syn - 3'd1];
      chk("inj_decoded", {fix[6], fix[5], fix[4], fix[2]}, 4'hF);
    end
`endif

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
